dht11_responder: RTL and testbench



---
 rtl/dht11_responder.sv | 161 ++++++++++++++++
 tb/tb_dht11_responder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: detects the host start pulse and answers with a 40-bit frame.
// Optional bus contention abort when DHT11_BUS_CHECK_EN is defined.
module dht11_responder #(
    parameter int unsigned MIN_START_LOW_CYC = 450000,
    parameter int unsigned HOST_REL_CYC      = 750,
    parameter int unsigned RESP_LOW_CYC      = 2000,
    parameter int unsigned RESP_HIGH_CYC     = 2000,
    parameter int unsigned BIT_LOW_CYC       = 1250,
    parameter int unsigned BIT0_HIGH_CYC     = 650,
    parameter int unsigned BIT1_HIGH_CYC     = 1750
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_bus,
    input  logic [31:0] i_data,
    output logic        o_bus_oe,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic        o_err
);

    typedef enum logic [2:0] {
        IDLE, HOST_LOW, WAIT_REL, RESP_LOW,
        RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW
    } state_t;

    localparam logic [19:0] MIN_C    = 20'(MIN_START_LOW_CYC);
    localparam logic [19:0] REL_L    = 20'(HOST_REL_CYC - 1);
    localparam logic [19:0] RESP_LO_L = 20'(RESP_LOW_CYC - 1);
    localparam logic [19:0] RESP_HI_L = 20'(RESP_HIGH_CYC - 1);
    localparam logic [19:0] BIT_LO_L = 20'(BIT_LOW_CYC - 1);
    localparam logic [19:0] B0_L     = 20'(BIT0_HIGH_CYC - 1);
    localparam logic [19:0] B1_L     = 20'(BIT1_HIGH_CYC - 1);

    state_t      state;
    logic [19:0] cnt;
    logic [39:0] shreg;
    logic [5:0]  bit_cnt;
    logic        sync1;
    logic        bus_s;
    logic [7:0]  csum;
    logic        abort;
    logic [19:0] high_last;

    always_comb begin
        csum = i_data[31:24] + i_data[23:16] + i_data[15:8] + i_data[7:0];
        high_last = shreg[39] ? B1_L : B0_L;
    end

`ifdef DHT11_BUS_CHECK_EN
    // From the 4th cycle of a released phase the synced bus must read high.
    assign abort = !bus_s && (cnt >= 20'd3);
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            shreg        <= '0;
            bit_cnt      <= '0;
            sync1        <= 1'b1;
            bus_s        <= 1'b1;
            o_bus_oe     <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            sync1        <= i_bus;
            bus_s        <= sync1;
            o_frame_done <= 1'b0;
            o_err        <= 1'b0;
            cnt          <= cnt + 20'd1;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!bus_s) begin
                        state <= HOST_LOW;
                        cnt   <= 20'd1;
                    end
                end
                HOST_LOW: begin
                    if (!bus_s) begin
                        cnt <= (cnt < MIN_C) ? cnt + 20'd1 : cnt;
                    end else if (cnt >= MIN_C) begin
                        state   <= WAIT_REL;
                        cnt     <= '0;
                        shreg   <= {i_data, csum};
                        bit_cnt <= '0;
                        o_busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                WAIT_REL: begin
                    if (cnt == REL_L) begin
                        state    <= RESP_LOW;
                        cnt      <= '0;
                        o_bus_oe <= 1'b1;
                    end
                end
                RESP_LOW: begin
                    if (cnt == RESP_LO_L) begin
                        state    <= RESP_HIGH;
                        cnt      <= '0;
                        o_bus_oe <= 1'b0;
                    end
                end
                RESP_HIGH: begin
                    if (abort) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        o_busy <= 1'b0;
                        o_err  <= 1'b1;
                    end else if (cnt == RESP_HI_L) begin
                        state    <= BIT_LOW;
                        cnt      <= '0;
                        o_bus_oe <= 1'b1;
                    end
                end
                BIT_LOW: begin
                    if (cnt == BIT_LO_L) begin
                        state    <= BIT_HIGH;
                        cnt      <= '0;
                        o_bus_oe <= 1'b0;
                    end
                end
                BIT_HIGH: begin
                    if (abort) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        o_busy <= 1'b0;
                        o_err  <= 1'b1;
                    end else if (cnt == high_last) begin
                        state    <= (bit_cnt == 6'd39) ? END_LOW : BIT_LOW;
                        cnt      <= '0;
                        shreg    <= {shreg[38:0], 1'b0};
                        bit_cnt  <= bit_cnt + 6'd1;
                        o_bus_oe <= 1'b1;
                    end
                end
                END_LOW: begin
                    if (cnt == BIT_LO_L) begin
                        state        <= IDLE;
                        cnt          <= '0;
                        o_bus_oe     <= 1'b0;
                        o_busy       <= 1'b0;
                        o_frame_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dht11_responder.sv
// Self-checking bench for dht11_responder: per-cycle compare against a phase-list model.
module tb_dht11_responder;

    localparam int MIN_S = 100;
    localparam int REL   = 10;
    localparam int RLO   = 20;
    localparam int RHI   = 20;
    localparam int BLO   = 12;
    localparam int B0    = 6;
    localparam int B1    = 17;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host = 1'b1;
    logic [31:0] i_data = '0;
    logic        oe, busy, done, err;
    wire         bus = oe ? 1'b0 : host;

    dht11_responder #(
        .MIN_START_LOW_CYC(MIN_S),
        .HOST_REL_CYC(REL),
        .RESP_LOW_CYC(RLO),
        .RESP_HIGH_CYC(RHI),
        .BIT_LOW_CYC(BLO),
        .BIT0_HIGH_CYC(B0),
        .BIT1_HIGH_CYC(B1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_bus(bus),
        .i_data(i_data),
        .o_bus_oe(oe),
        .o_busy(busy),
        .o_frame_done(done),
        .o_err(err)
    );

    always #5 clk = ~clk;

    // {oe, busy, done, err} expected for one sampled cycle
    typedef struct packed {
        logic oe;
        logic busy;
        logic done;
        logic err;
    } exp_t;

    exp_t exp_q[$];
    exp_t fr_q[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk("outputs{oe,busy,done,err}", {60'd0, oe, busy, done, err},
            {60'd0, e});
    end

    // Decode released-phase lengths back into bits
    int          rel_run = 0;
    int          nb = 0;
    int          nerr = 0;
    int          ndec = 0;
    logic [39:0] dec = '0;
    logic [39:0] last_dec = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            rel_run = 0;
            nb = 0;
            dec = '0;
        end else begin
            if (err) begin
                nerr++;
                nb = 0;
                rel_run = 0;
            end
            if (busy && !oe) begin
                rel_run++;
            end else begin
                if (rel_run == B0 || rel_run == B1) begin
                    dec = {dec[38:0], 1'(rel_run == B1)};
                    nb++;
                end
                rel_run = 0;
            end
            if (done) begin
                last_dec = dec;
                ndec = nb;
                nb = 0;
            end
        end
    end

    function automatic logic [7:0] csum(input logic [31:0] d);
        return d[31:24] + d[23:16] + d[15:8] + d[7:0];
    endfunction

    function automatic int bit_len(input logic [39:0] f, input int b);
        return f[39-b] ? B1 : B0;
    endfunction

    function automatic int low_start(input logic [39:0] f, input int b);
        int s;
        s = REL + RLO + RHI;
        for (int k = 0; k < b; k++) s += BLO + bit_len(f, k);
        return s;
    endfunction

    task automatic phase(input int n, input logic o);
        repeat (n) fr_q.push_back(exp_t'({o, 1'b1, 2'b00}));
    endtask

    task automatic build(input logic [39:0] f);
        fr_q.delete();
        phase(REL, 1'b0);
        phase(RLO, 1'b1);
        phase(RHI, 1'b0);
        for (int b = 0; b < 40; b++) begin
            phase(BLO, 1'b1);
            phase(bit_len(f, b), 1'b0);
        end
        phase(BLO, 1'b1);
        fr_q.push_back(exp_t'(4'b0010));
    endtask

    // Three idle samples cover the 2-flop sync plus the detecting edge
    task automatic enqueue(input int keep, input bit add_err);
        repeat (3) exp_q.push_back('0);
        for (int i = 0; i < keep; i++) exp_q.push_back(fr_q[i]);
        if (add_err) exp_q.push_back(exp_t'(4'b0001));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic host_low(input int n);
        host = 1'b0;
        tick(n);
        host = 1'b1;
    endtask

    task automatic wait_q();
        int c;
        c = 0;
        do begin
            @(posedge clk);
            c++;
        end while (exp_q.size() > 0 && c < 5000);
        #1;
        chk("frame_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic run_frame(input logic [31:0] d, input int low);
        logic [39:0] f;
        f = {d, csum(d)};
        i_data = d;
        last_dec = '0;
        ndec = 0;
        host_low(low);
        if (low >= MIN_S) begin
            build(f);
            enqueue(fr_q.size(), 1'b0);
            tick(8);
            i_data = $urandom;
            wait_q();
            chk("decode", 64'(last_dec), 64'(f));
            chk("bit_count", 64'(ndec), 64'd40);
        end else begin
            tick(10);
        end
        tick(5);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [39:0] f;
        logic [31:0] d;
        int j;

        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(50);

        chk("csum_3C001A05", 64'(csum(32'h3C001A05)), 64'h5B);
        chk("csum_FFFF0102", 64'(csum(32'hFFFF0102)), 64'h01);

        run_frame(32'h12345678, 60);
        run_frame(32'h12345678, MIN_S - 1);

        run_frame(32'h3C001A05, 120);
        chk("decode_lit_a", 64'(last_dec), 64'h3C001A055B);

        run_frame(32'hFFFF0102, 110);
        chk("decode_lit_b", 64'(last_dec), 64'hFFFF010201);

        run_frame(32'hA5C3_0F81, MIN_S);

        // Reset during bit 10
        d = $urandom;
        f = {d, csum(d)};
        i_data = d;
        host_low(105);
        build(f);
        enqueue(fr_q.size(), 1'b0);
        tick(3 + low_start(f, 10) + 4);
        rst_n = 1'b0;
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        tick(2);
        chk("rst_oe", 64'(oe), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        tick(10);
        run_frame($urandom, 100);

        // Bus pulled low on the 5th cycle of bit 2's released phase
        d = 32'h3C001A05;
        f = {d, csum(d)};
        j = low_start(f, 2) + BLO + 4;
        nerr = 0;
        i_data = d;
        last_dec = '0;
        ndec = 0;
        host_low(120);
        build(f);
`ifdef DHT11_BUS_CHECK_EN
        enqueue(j + 3, 1'b1);
`else
        enqueue(fr_q.size(), 1'b0);
`endif
        tick(3 + j);
        host = 1'b0;
        tick(4);
        host = 1'b1;
        wait_q();
`ifdef DHT11_BUS_CHECK_EN
        chk("err_pulses", 64'(nerr), 64'd1);
        chk("no_decode", 64'(ndec), 64'd0);
`else
        chk("err_pulses", 64'(nerr), 64'd0);
        chk("decode_contend", 64'(last_dec), 64'h3C001A055B);
`endif
        tick(20);

        repeat (4) begin
            run_frame($urandom, $urandom_range(1, MIN_S - 1));
            run_frame($urandom, $urandom_range(MIN_S, MIN_S + 40));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
